mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single-ported SoC memory port between the CPU and a second requester, such as a DMA or boot loader. It uses the native memory protocol: addr, wdata, 4-bit wmask, rstrb, rdata. It adds a per-master completion pulse so that a master can be stalled. It sits between the masters and the RAM/IO address decode in the SOC top.

---
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: two requesting masters and one memory slave,
// all using the native memory protocol (addr, wdata, wmask, rstrb, rdata) plus
// a per-master completion pulse.
//   slave  modport: the arbiter's view (it serves both masters, drives the slave port)
//   master modport: the environment's view (requesters and the memory behind s_*)
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m0_addr;
    logic [DATA_W-1:0]   m0_wdata;
    logic [DATA_W/8-1:0] m0_wmask;
    logic                m0_rstrb;
    logic [DATA_W-1:0]   m0_rdata;
    logic                m0_done;

    logic [ADDR_W-1:0]   m1_addr;
    logic [DATA_W-1:0]   m1_wdata;
    logic [DATA_W/8-1:0] m1_wmask;
    logic                m1_rstrb;
    logic [DATA_W-1:0]   m1_rdata;
    logic                m1_done;

    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wmask;
    logic                s_rstrb;
    logic [DATA_W-1:0]   s_rdata;

    logic                busy;

    modport slave (
        input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
        input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
        input  s_rdata,
        output m0_rdata, m0_done, m1_rdata, m1_done,
        output s_addr, s_wdata, s_wmask, s_rstrb,
        output busy
    );

    modport master (
        output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
        output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
        output s_rdata,
        input  m0_rdata, m0_done, m1_rdata, m1_done,
        input  s_addr, s_wdata, s_wmask, s_rstrb,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory between two masters.
// Round-robin on conflict (master 0 wins the first one after reset), one
// ISSUE cycle per transaction, reads wait READ_LAT cycles for slave data.
// Optional statistics counters are built when the macro ARB_STATS_EN is defined.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_arbiter_if.slave     bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          m0_gnt_cnt,
    output logic [15:0]          m1_gnt_cnt,
    output logic [15:0]          conflict_cnt
`endif
);
    localparam int MASK_W = DATA_W / 8;
    // lat_cnt counts the remaining RWAIT cycles; READ_LAT is limited to 1..4
    localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;          // 0 = master 0, 1 = master 1
    logic                last_gnt_q, last_gnt_d;
    logic [1:0]          lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    logic                req0, req1;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic [MASK_W-1:0]   g_wmask;
    logic [MASK_W-1:0]   s_wmask_c;
    logic                s_rstrb_c;
    logic                done_c;

    assign req0 = bus.m0_rstrb | (|bus.m0_wmask);
    assign req1 = bus.m1_rstrb | (|bus.m1_wmask);

    // Request fields of the currently granted master
    assign g_addr  = gnt_q ? bus.m1_addr  : bus.m0_addr;
    assign g_wdata = gnt_q ? bus.m1_wdata : bus.m0_wdata;
    assign g_wmask = gnt_q ? bus.m1_wmask : bus.m0_wmask;

    // Next-state, grant decision and slave/master strobes
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        lat_cnt_d  = lat_cnt_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        s_wmask_c  = '0;
        s_rstrb_c  = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        gnt_d = ~last_gnt_q;
                    end else begin
                        gnt_d = req1;
                    end
                    last_gnt_d = gnt_d;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                s_addr_d  = g_addr;
                s_wdata_d = g_wdata;
                // A nonzero mask makes it a write even if rstrb is also high
                if (|g_wmask) begin
                    s_wmask_c = g_wmask;
                    done_c    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    s_rstrb_c = 1'b1;
                    lat_cnt_d = LAT_INIT;
                    state_d   = RWAIT;
                end
            end
            RWAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    done_c = 1'b1;
                    if (gnt_q) begin
                        m1_rdata_d = bus.s_rdata;
                    end else begin
                        m0_rdata_d = bus.s_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            lat_cnt_q  <= 2'd0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            lat_cnt_q  <= lat_cnt_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Address/data follow the granted master during ISSUE and hold otherwise;
    // read data is forwarded to the master in the same cycle as its done pulse
    assign bus.s_addr   = s_addr_d;
    assign bus.s_wdata  = s_wdata_d;
    assign bus.s_wmask  = s_wmask_c;
    assign bus.s_rstrb  = s_rstrb_c;
    assign bus.m0_done  = done_c & ~gnt_q;
    assign bus.m1_done  = done_c &  gnt_q;
    assign bus.m0_rdata = m0_rdata_d;
    assign bus.m1_rdata = m1_rdata_d;
    assign bus.busy     = (state_q != IDLE);

`ifdef ARB_STATS_EN
    logic [15:0] m0_gnt_cnt_q, m0_gnt_cnt_d;
    logic [15:0] m1_gnt_cnt_q, m1_gnt_cnt_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // Saturating grant and conflict counters
    always_comb begin
        m0_gnt_cnt_d   = sat_inc(m0_gnt_cnt_q, (state_q == ISSUE) && !gnt_q);
        m1_gnt_cnt_d   = sat_inc(m1_gnt_cnt_q, (state_q == ISSUE) &&  gnt_q);
        conflict_cnt_d = sat_inc(conflict_cnt_q, (state_q == IDLE) && req0 && req1);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_gnt_cnt_q   <= 16'd0;
            m1_gnt_cnt_q   <= 16'd0;
            conflict_cnt_q <= 16'd0;
        end else begin
            m0_gnt_cnt_q   <= m0_gnt_cnt_d;
            m1_gnt_cnt_q   <= m1_gnt_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign m0_gnt_cnt   = m0_gnt_cnt_q;
    assign m1_gnt_cnt   = m1_gnt_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, hand-written reset /
// conflict / back-to-back sequences, and two randomized masters checked
// against a word-level golden memory.
module tb_mem_bus_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int READ_LAT = 2;
    localparam int N_RAND   = 60;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] m0_gnt_cnt, m1_gnt_cnt, conflict_cnt;
`endif

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_STATS_EN
        ,
        .m0_gnt_cnt   (m0_gnt_cnt),
        .m1_gnt_cnt   (m1_gnt_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] mk);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (mk[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Slave memory: byte-masked writes, reads valid READ_LAT cycles after s_rstrb
    logic [31:0] smem [1024] = '{default: 32'h0};
    logic [31:0] rd_pipe [READ_LAT];
    always @(posedge clk) begin
        if (bus.s_wmask != 4'h0) smem[idx(bus.s_addr)] <= merge(smem[idx(bus.s_addr)], bus.s_wdata, bus.s_wmask);
        rd_pipe[0] <= bus.s_rstrb ? smem[idx(bus.s_addr)] : 32'hBAD0_BAD0;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.s_rdata = rd_pipe[READ_LAT-1];

    // Golden memory used by the randomized masters
    logic [31:0] gold [1024] = '{default: 32'h0};

    task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk, input logic rs);
        if (m == 0) begin
            bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wmask = mk; bus.m0_rstrb = rs;
        end else begin
            bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wmask = mk; bus.m1_rstrb = rs;
        end
    endtask

    task automatic clear_req(input int m);
        set_req(m, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    function automatic logic get_done(input int m);
        return (m == 0) ? bus.m0_done : bus.m1_done;
    endfunction

    function automatic logic [31:0] get_rdata(input int m);
        return (m == 0) ? bus.m0_rdata : bus.m1_rdata;
    endfunction

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rstrb;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    // One isolated transaction from IDLE: latency, strobes, data, other done
    task automatic run_vec(input vec_t v, input string nm);
        int lat, nrs, odone;
        logic [3:0] wm_seen;
        logic got;
        logic [31:0] rd;
        lat = 0; nrs = 0; odone = 0; wm_seen = 4'h0; got = 1'b0; rd = 32'h0;
        @(posedge clk); #1;
        set_req(v.m, v.addr, v.wdata, v.wmask, v.rstrb);
        while (!got && lat < 20) begin
            @(negedge clk);
            if (bus.s_rstrb) nrs++;
            if (bus.s_wmask != 4'h0) wm_seen = bus.s_wmask;
            if (get_done(1 - v.m)) odone++;
            if (get_done(v.m)) begin
                got = 1'b1;
                rd  = get_rdata(v.m);
            end else begin
                lat++;
            end
        end
        check({nm, "_done_seen"}, 32'(got), 32'd1);
        check({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({nm, "_other_done"}, 32'(odone), 32'd0);
        if (v.wmask != 4'h0) begin
            check({nm, "_s_wmask"}, 32'(wm_seen), 32'(v.wmask));
            check({nm, "_no_rstrb"}, 32'(nrs), 32'd0);
        end else begin
            check({nm, "_rstrb_cycles"}, 32'(nrs), 32'd1);
            check({nm, "_rdata"}, rd, v.exp_rdata);
        end
        @(posedge clk); #1;
        clear_req(v.m);
        @(negedge clk);
        check({nm, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({nm, "_wmask_after"}, 32'(bus.s_wmask), 32'd0);
        if (v.wmask == 4'h0) check({nm, "_rdata_hold"}, get_rdata(v.m), v.exp_rdata);
    endtask

    int agents_done = 0;

    // Randomized master: random gaps, reads/writes with random masks, golden-checked
    task automatic agent(input int m, input int n);
        int gap, cyc;
        logic got;
        logic [31:0] a, d;
        logic [3:0] mk;
        logic rs;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            @(posedge clk); #1;
            for (int g = 0; g < gap; g++) begin
                clear_req(m);
                @(posedge clk); #1;
            end
            a  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            d  = $urandom;
            mk = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) mk = 4'h0;
            rs = (mk == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
            set_req(m, a, d, mk, rs);
            cyc = 0; got = 1'b0;
            while (!got && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (get_done(m)) got = 1'b1;
            end
            check($sformatf("rnd_m%0d_done_seen", m), 32'(got), 32'd1);
            if (!got) break;
            if (mk != 4'h0) begin
                check($sformatf("rnd_m%0d_s_wmask", m), 32'(bus.s_wmask), 32'(mk));
                check($sformatf("rnd_m%0d_s_addr", m), bus.s_addr, a);
                check($sformatf("rnd_m%0d_s_wdata", m), bus.s_wdata, d);
                gold[idx(a)] = merge(gold[idx(a)], d, mk);
            end else begin
                check($sformatf("rnd_m%0d_rdata", m), get_rdata(m), gold[idx(a)]);
            end
        end
        @(posedge clk); #1;
        clear_req(m);
        agents_done++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int q_m [$];
        logic [31:0] q_d [$];
        int cyc, phase, wm_out;
        int iss [$];
        logic busy_tr [64];
        logic [31:0] rd;
        vec_t v;

        vecs[0] = '{0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1, 32'h0};
        vecs[1] = '{0, 32'h200, 32'h12345678, 4'hF, 1'b0, 1, 32'h0};
        vecs[2] = '{1, 32'h200, 32'h0,        4'h0, 1'b1, READ_LAT + 1, 32'h12345678};
        vecs[3] = '{0, 32'h100, 32'h0,        4'h0, 1'b1, READ_LAT + 1, 32'hDEADBEEF};
        vecs[4] = '{1, 32'h300, 32'hAABBCCDD, 4'hF, 1'b0, 1, 32'h0};
        vecs[5] = '{1, 32'h300, 32'h11223344, 4'h3, 1'b0, 1, 32'h0};
        vecs[6] = '{0, 32'h300, 32'h0,        4'h0, 1'b1, READ_LAT + 1, 32'hAABB3344};
        vecs[7] = '{1, 32'h400, 32'h00000000, 4'hF, 1'b0, 1, 32'h0};
        vecs[8] = '{0, 32'h400, 32'h55667788, 4'h3, 1'b1, 1, 32'h0};
        vecs[9] = '{1, 32'h400, 32'h0,        4'h0, 1'b1, READ_LAT + 1, 32'h00007788};

        clear_req(0);
        clear_req(1);
        reset = 1'b1;
        #2;
        check("rst_s_rstrb", 32'(bus.s_rstrb), 32'd0);
        check("rst_s_wmask", 32'(bus.s_wmask), 32'd0);
        check("rst_s_addr", bus.s_addr, 32'd0);
        check("rst_s_wdata", bus.s_wdata, 32'd0);
        check("rst_m0_done", 32'(bus.m0_done), 32'd0);
        check("rst_m1_done", 32'(bus.m1_done), 32'd0);
        check("rst_m0_rdata", bus.m0_rdata, 32'd0);
        check("rst_m1_rdata", bus.m1_rdata, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during RWAIT of a master 0 read
        @(posedge clk); #1;
        set_req(0, 32'h100, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_rstrb_issue", 32'(bus.s_rstrb), 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rstmid_s_rstrb", 32'(bus.s_rstrb), 32'd0);
        check("rstmid_s_wmask", 32'(bus.s_wmask), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_m0_done", 32'(bus.m0_done), 32'd0);
        clear_req(0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_no_done", 32'(bus.m0_done | bus.m1_done), 32'd0);
        end
        check("rstmid_m0_rdata", bus.m0_rdata, 32'd0);

        // Reset during the ISSUE cycle of a master 1 write: strobe aborted
        @(posedge clk); #1;
        set_req(1, 32'h700, 32'hFFFFFFFF, 4'hF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("wabort_wmask_issue", 32'(bus.s_wmask), 32'hF);
        #1 reset = 1'b1;
        #1;
        check("wabort_s_wmask", 32'(bus.s_wmask), 32'd0);
        check("wabort_m1_done", 32'(bus.m1_done), 32'd0);
        clear_req(1);
        @(negedge clk);
        reset = 1'b0;
        v = '{1, 32'h700, 32'h0, 4'h0, 1'b1, READ_LAT + 1, 32'h0};
        run_vec(v, "wabort_readback");

        // Conflict: both masters read continuously; first four grants
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        set_req(0, 32'h100, 32'h0, 4'h0, 1'b1);
        set_req(1, 32'h200, 32'h0, 4'h0, 1'b1);
        cyc = 0;
        while (q_m.size() < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.m0_done) begin q_m.push_back(0); q_d.push_back(bus.m0_rdata); end
            if (bus.m1_done) begin q_m.push_back(1); q_d.push_back(bus.m1_rdata); end
        end
        @(posedge clk); #1;
        clear_req(0);
        clear_req(1);
        check("conf_count", 32'(q_m.size()), 32'd4);
        for (int i = 0; i < q_m.size() && i < 4; i++) begin
            check($sformatf("conf_order%0d", i), 32'(q_m[i]), 32'(i % 2));
            check($sformatf("conf_rdata%0d", i), q_d[i], (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("conf_no_extra_done", 32'(bus.m0_done | bus.m1_done), 32'd0);
        end
`ifdef ARB_STATS_EN
        check("conf_conflict_cnt", 32'(conflict_cnt), 32'd4);
        check("conf_m0_gnt_cnt", 32'(m0_gnt_cnt), 32'd2);
        check("conf_m1_gnt_cnt", 32'(m1_gnt_cnt), 32'd2);
`endif

        // Back-to-back: write, then read presented the cycle after done
        @(posedge clk); #1;
        set_req(0, 32'h600, 32'hCAFEF00D, 4'hF, 1'b0);
        cyc = 0; phase = 0; wm_out = 0; rd = 32'h0;
        while (phase < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            busy_tr[cyc] = bus.busy;
            if (bus.s_wmask != 4'h0 || bus.s_rstrb) iss.push_back(cyc);
            if (bus.s_wmask != 4'h0 && !bus.m0_done) wm_out++;
            if (bus.m0_done) begin
                if (phase == 0) begin
                    phase = 1;
                    @(posedge clk); #1;
                    set_req(0, 32'h600, 32'h0, 4'h0, 1'b1);
                end else begin
                    phase = 2;
                    rd = bus.m0_rdata;
                end
            end
        end
        @(posedge clk); #1;
        clear_req(0);
        check("b2b_finished", 32'(phase), 32'd2);
        check("b2b_issue_count", 32'(iss.size()), 32'd2);
        if (iss.size() == 2) begin
            check("b2b_issue_gap", 32'(iss[1] - iss[0]), 32'd2);
            check("b2b_idle_between", 32'(busy_tr[iss[0] + 1]), 32'd0);
        end
        check("b2b_wmask_outside_issue", 32'(wm_out), 32'd0);
        check("b2b_rdata", rd, 32'hCAFEF00D);

        // Randomized traffic from both masters with a bus monitor
        fork
            agent(0, N_RAND);
            agent(1, N_RAND);
            begin
                while (agents_done < 2) begin
                    @(negedge clk);
                    check("mon_single_done", 32'(bus.m0_done & bus.m1_done), 32'd0);
                    if (bus.s_wmask != 4'h0) check("mon_wmask_with_done", 32'(bus.m0_done | bus.m1_done), 32'd1);
                end
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
